// File: rtl/dm_arbiter_pkg.sv
// Shared op codes, FSM encoding and byte-enable helpers for the data-memory arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dm_arbiter_pkg;

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Byte-lane enables for an aligned access; illegal ops enable nothing.
    function automatic logic [3:0] be_of(input logic [1:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            OP_WORD: be = 4'b1111;
            OP_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            OP_BYTE: be = 4'b0001 << a;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Misaligned or illegal access.
    function automatic logic err_of(input logic [1:0] op, input logic [1:0] a);
        return (op == OP_ILL) ||
               ((op == OP_HALF) && a[0]) ||
               ((op == OP_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Lane steering: byte enables, replicated store data, error flag and extended load result.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module dm_lane_unit
    import dm_arbiter_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic        sext_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    output logic [31:0] result_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Error/enables, store replication and load lane extraction with extension.
    always_comb begin
        err_o    = err_of(op_i, addr_lo_i);
        be_o     = err_o ? 4'b0000 : be_of(op_i, addr_lo_i);

        case (op_i)
            OP_HALF: wdata_o = {2{wdata_i[15:0]}};
            OP_BYTE: wdata_o = {4{wdata_i[7:0]}};
            default: wdata_o = wdata_i;
        endcase

        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        case (op_i)
            OP_HALF: result_o = {{16{sext_i & half_sel[15]}}, half_sel};
            OP_BYTE: result_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between two requesters.
// Latency: request sampled at edge N, memory written at edge N+1, ack during the following cycle; 1 access / 3 cycles.
// Backpressure: requesters hold req and fields until ack; the losing port simply waits unsampled.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic          sext0,
    input  logic          sext1,
    input  logic [31:0]   addr0,
    input  logic [31:0]   addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            win_q, win_d;
    logic            we_q, we_d;
    logic [1:0]      op_q, op_d;
    logic            sext_q, sext_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     result_q, result_d;

    logic            gnt_any;
    logic            gnt_sel;
    logic            in_idle;
    logic [1:0]      lane_op;
    logic            lane_sext;
    logic [1:0]      lane_addr_lo;
    logic [31:0]     lane_wdata_in;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic            lane_err;
    logic [31:0]     lane_result;

    // Address bits above the memory window are deliberately ignored.
    logic            unused_hi;
    assign unused_hi = ^{addr0[31:AW+2], addr1[31:AW+2]};

    // Winner: the pointer breaks ties, otherwise whichever port asks.
    always_comb begin
        gnt_any = req0 | req1;
        gnt_sel = (req0 & req1) ? ptr_q : req1;
        in_idle = (state_q == ST_IDLE);
    end

    // The lane unit sees the prospective winner in IDLE (to latch err) and the latched request afterwards.
    always_comb begin
        lane_op       = in_idle ? (gnt_sel ? op1 : op0)                 : op_q;
        lane_sext     = in_idle ? (gnt_sel ? sext1 : sext0)             : sext_q;
        lane_addr_lo  = in_idle ? (gnt_sel ? addr1[1:0] : addr0[1:0])   : addr_q[1:0];
        lane_wdata_in = in_idle ? (gnt_sel ? wdata1 : wdata0)           : wdata_q;
    end

    dm_lane_unit u_lane (
        .op_i      (lane_op),
        .sext_i    (lane_sext),
        .addr_lo_i (lane_addr_lo),
        .wdata_i   (lane_wdata_in),
        .rdata_i   (mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .err_o     (lane_err),
        .result_o  (lane_result)
    );

    // Next-state and outputs; everything is masked while reset is low so an in-flight write or ack is dropped.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        op_d      = op_q;
        sext_d    = sext_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        result_d  = result_q;

        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        err0      = 1'b0;
        err1      = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        busy      = reset & ~in_idle;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    win_d   = gnt_sel;
                    we_d    = gnt_sel ? we1 : we0;
                    op_d    = lane_op;
                    sext_d  = lane_sext;
                    addr_d  = gnt_sel ? addr1[AW+1:0] : addr0[AW+1:0];
                    wdata_d = lane_wdata_in;
                    err_d   = lane_err;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (reset) begin
                    mem_addr  = addr_q[AW+1:2];
                    mem_we    = we_q & ~err_q;
                    mem_be    = lane_be;
                    mem_wdata = lane_wdata;
                end
                result_d = we_q ? 32'd0 : lane_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (reset) begin
                    ack0   = ~win_q;
                    ack1   = win_q;
                    rdata0 = win_q ? 32'd0 : result_q;
                    rdata1 = win_q ? result_q : 32'd0;
                    err0   = ~win_q & err_q;
                    err1   = win_q & err_q;
                end
                ptr_d   = ~win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= RR_INIT;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            op_q     <= OP_WORD;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            op_q     <= op_d;
            sext_q   <= sext_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural word memory.
// Latency: checks ACCESS one edge after sampling and ack one edge later.
// Backpressure: both requesters held under contention to check strict alternation.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, sext0, sext1;
    logic [1:0]  op0, op1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;

    bit [31:0]   mem [0:4095];
    int          wr_cnt = 0;
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_dat = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(12), .RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .op0(op0), .op1(op1), .sext0(sext0), .sext1(sext1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port memory: combinational read, byte-enabled write, plus a preload port.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_dat;
        if (mem_we) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit we, input logic [1:0] op, input bit sx,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            we1 = we; op1 = op; sext1 = sx; addr1 = a; wdata1 = d;
        end else begin
            we0 = we; op0 = op; sext0 = sx; addr0 = a; wdata0 = d;
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  op;
        bit          sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic run_vec(input int i, input vec_t v);
        @(negedge clk);
        drive(v.port, v.we, v.op, v.sext, v.addr, v.wdata);
        if (v.port) req1 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_maddr", i), 32'(mem_addr), v.exp_maddr);
        chk($sformatf("v%0d_be", i), 32'(mem_be), 32'(v.exp_be));
        chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(v.we & ~v.exp_err));
        chk($sformatf("v%0d_mwdata", i), mem_wdata, v.exp_mwdata);
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack", i), 32'(v.port ? ack1 : ack0), 32'd1);
        chk($sformatf("v%0d_other_ack", i), 32'(v.port ? ack0 : ack1), 32'd0);
        chk($sformatf("v%0d_rdata", i), v.port ? rdata1 : rdata0, v.exp_rdata);
        chk($sformatf("v%0d_err", i), 32'(v.port ? err1 : err0), 32'(v.exp_err));
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset with both ports requesting word stores.
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'hA000_0000);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'hB000_0000);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_ack", 32'({ack0, ack1}), 32'd0);
            chk("rst_be", 32'(mem_be), 32'd0);
            chk("rst_data", 32'(|{rdata0, rdata1, err0, err1, mem_addr, mem_wdata}), 32'd0);
        end
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Continuous contention: strict 0,1,0,1 alternation, each port advancing its address on ack.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d_maddr", k), 32'(mem_addr), (k % 2 == 0) ? 32'h40 + k/2 : 32'h80 + k/2);
            chk($sformatf("rr%0d_we", k), 32'(mem_we), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_ack0", k), 32'(ack0), 32'(k % 2 == 0));
            chk($sformatf("rr%0d_ack1", k), 32'(ack1), 32'(k % 2 == 1));
            if (k % 2 == 0) drive(1'b0, 1'b1, 2'b00, 1'b0, addr0 + 32'd4, 32'hA000_0000 | (k/2 + 1));
            else            drive(1'b1, 1'b1, 2'b00, 1'b0, addr1 + 32'd4, 32'hB000_0000 | (k/2 + 1));
            if (k == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        chk("rr_wr_cnt", 32'(wr_cnt), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rr_mem0_%0d", i), mem[12'h40 + 12'(i)], 32'hA000_0000 | i);
            chk($sformatf("rr_mem1_%0d", i), mem[12'h80 + 12'(i)], 32'hB000_0000 | i);
        end

        // Reset during ACCESS drops the write and ack; the held request is re-granted afterwards.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h1234_5678);
        req1 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_ack", 32'(ack1), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem", mem[8], 32'd0);
        chk("mid_rst_wr_cnt", 32'(wr_cnt), 32'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("regrant_we", 32'(mem_we), 32'd1);
        chk("regrant_maddr", 32'(mem_addr), 32'd8);
        @(posedge clk); #1;
        chk("regrant_ack", 32'(ack1), 32'd1);
        chk("regrant_err", 32'(err1), 32'd0);
        req1 = 1'b0;
        @(posedge clk); #1;
        chk("regrant_mem", mem[8], 32'h1234_5678);

        // Preload word 1 for the load vectors.
        @(negedge clk);
        pre_en = 1'b1; pre_addr = 12'd1; pre_dat = 32'h8001_FF7F;
        @(negedge clk);
        pre_en = 1'b0;

        //            port we  op     sx  addr          wdata         maddr be       mwdata        err rdata
        vecs[0]  = '{1'b0, 0, 2'b01, 1, 32'h0000_0006, 32'h0,        32'd1, 4'b1100, 32'h0,        0, 32'hFFFF_8001};
        vecs[1]  = '{1'b0, 0, 2'b10, 0, 32'h0000_0004, 32'h0,        32'd1, 4'b0001, 32'h0,        0, 32'h0000_007F};
        vecs[2]  = '{1'b0, 0, 2'b10, 1, 32'h0000_0005, 32'h0,        32'd1, 4'b0010, 32'h0,        0, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 0, 2'b01, 0, 32'h0000_0004, 32'h0,        32'd1, 4'b0011, 32'h0,        0, 32'h0000_FF7F};
        vecs[4]  = '{1'b1, 0, 2'b00, 0, 32'h0000_0004, 32'h0,        32'd1, 4'b1111, 32'h0,        0, 32'h8001_FF7F};
        vecs[5]  = '{1'b0, 1, 2'b10, 0, 32'h0000_0006, 32'h0000_00AB, 32'd1, 4'b0100, 32'hABAB_ABAB, 0, 32'h0};
        vecs[6]  = '{1'b0, 0, 2'b00, 0, 32'h0000_0004, 32'h0,        32'd1, 4'b1111, 32'h0,        0, 32'h80AB_FF7F};
        vecs[7]  = '{1'b1, 1, 2'b01, 0, 32'h0000_000A, 32'h0000_1234, 32'd2, 4'b1100, 32'h1234_1234, 0, 32'h0};
        vecs[8]  = '{1'b1, 0, 2'b00, 0, 32'h0000_0008, 32'h0,        32'd2, 4'b1111, 32'h0,        0, 32'h1234_0000};
        vecs[9]  = '{1'b0, 1, 2'b00, 0, 32'h0000_0002, 32'hDEAD_BEEF, 32'd0, 4'b0000, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[10] = '{1'b1, 1, 2'b11, 0, 32'h0000_000C, 32'h0,        32'd3, 4'b0000, 32'h0,        1, 32'h0};
        vecs[11] = '{1'b0, 0, 2'b00, 0, 32'h0000_0000, 32'h0,        32'd0, 4'b1111, 32'h0,        0, 32'h0};
        vecs[12] = '{1'b1, 1, 2'b01, 0, 32'h0000_0007, 32'h0000_5555, 32'd1, 4'b0000, 32'h5555_5555, 1, 32'h0};
        vecs[13] = '{1'b0, 0, 2'b00, 0, 32'hFFFF_4008, 32'h0,        32'd2, 4'b1111, 32'h0,        0, 32'h1234_0000};
        vecs[14] = '{1'b1, 1, 2'b10, 0, 32'h0000_000B, 32'h0000_01FF, 32'd2, 4'b1000, 32'hFFFF_FFFF, 0, 32'h0};
        vecs[15] = '{1'b1, 0, 2'b10, 0, 32'h0000_000B, 32'h0,        32'd2, 4'b1000, 32'h0,        0, 32'h0000_00FF};
        vecs[16] = '{1'b0, 0, 2'b00, 0, 32'h0000_0004, 32'h0,        32'd1, 4'b1111, 32'h0,        0, 32'h80AB_FF7F};

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        chk("final_mem0", mem[0], 32'h0);
        chk("final_mem2", mem[2], 32'hFF34_0000);
        chk("final_mem3", mem[3], 32'h0);
        chk("final_wr_cnt", 32'(wr_cnt), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
